// File: rtl/fft_unscrambler_if.sv
// Read port of the ping-pong result RAM plus the natural-order output stream of fft_unscrambler.
// out_idx is present only when FFT_UNSCR_IDX_EN is defined.
interface fft_unscrambler_if #(
  parameter int BITS_PER_ROW = 3,
  parameter int DATA_W       = 32
);
  logic                    mem_rd_en;
  logic                    mem_rd_bank;
  logic [BITS_PER_ROW-1:0] mem_rd_addr;
  logic [DATA_W-1:0]       mem_rd_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_data;
  logic                    out_last;
`ifdef FFT_UNSCR_IDX_EN
  logic [BITS_PER_ROW-1:0] out_idx;

  modport master (
    output mem_rd_en, mem_rd_bank, mem_rd_addr,
    input  mem_rd_data,
    output out_valid, out_data, out_last, out_idx,
    input  out_ready
  );

  modport slave (
    input  mem_rd_en, mem_rd_bank, mem_rd_addr,
    output mem_rd_data,
    input  out_valid, out_data, out_last, out_idx,
    output out_ready
  );
`else
  modport master (
    output mem_rd_en, mem_rd_bank, mem_rd_addr,
    input  mem_rd_data,
    output out_valid, out_data, out_last,
    input  out_ready
  );

  modport slave (
    input  mem_rd_en, mem_rd_bank, mem_rd_addr,
    output mem_rd_data,
    input  out_valid, out_data, out_last,
    output out_ready
  );
`endif
endinterface

// File: rtl/fft_unscrambler.sv
// Streams a bit-reversed FFT result bank out in natural bin order through a 2-entry skid FIFO.
// Optional FFT_UNSCR_IDX_EN: carries the natural bin index with each beat on out_idx.
module fft_unscrambler #(
  parameter int N            = 8,
  parameter int BITS_PER_ROW = 3,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              bank_sel,
  output logic              busy,
  output logic              done,
  fft_unscrambler_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  typedef struct packed {
    logic                    last;
`ifdef FFT_UNSCR_IDX_EN
    logic [BITS_PER_ROW-1:0] idx;
`endif
    logic [DATA_W-1:0]       data;
  } entry_t;

  localparam logic [BITS_PER_ROW-1:0] LAST_IDX = BITS_PER_ROW'(N - 1);

  function automatic logic [BITS_PER_ROW-1:0] bit_rev(input logic [BITS_PER_ROW-1:0] v);
    logic [BITS_PER_ROW-1:0] r;
    r = '0;
    for (int i = 0; i < BITS_PER_ROW; i++) begin
      r[BITS_PER_ROW-1-i] = v[i];
    end
    return r;
  endfunction

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [BITS_PER_ROW-1:0] rd_idx_r;
  logic                    bank_r;
  logic                    inflight_r;
  logic                    inflight_last_r;
`ifdef FFT_UNSCR_IDX_EN
  logic [BITS_PER_ROW-1:0] inflight_idx_r;
`endif
  entry_t                  head_r;
  entry_t                  tail_r;
  entry_t                  push_entry_s;
  logic [1:0]              count_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    busy_nxt_s;
  logic                    done_nxt_s;
  logic                    start_acc_s;
  logic                    pop_s;
  logic                    push_s;
  logic                    issue_s;
  logic                    last_issue_s;
  logic                    beat_last_s;
  logic [2:0]              occ_s;

  assign start_acc_s  = start && (state_r == IDLE);
  assign pop_s        = (count_r != 2'd0) && bus.out_ready;
  assign push_s       = inflight_r;
  assign beat_last_s  = pop_s && head_r.last;
  // Occupancy once this cycle's pop is taken out; keeps a full-rate stream going without overflow.
  assign occ_s        = 3'(count_r) + 3'(inflight_r) - 3'(pop_s);
  assign last_issue_s = issue_s && (rd_idx_r == LAST_IDX);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_acc_s) state_nxt_s = READ;
        else             state_nxt_s = IDLE;
      end
      READ: begin
        if (last_issue_s) state_nxt_s = DRAIN;
        else              state_nxt_s = READ;
      end
      DRAIN: begin
        if (beat_last_s) state_nxt_s = FIN;
        else             state_nxt_s = DRAIN;
      end
      FIN:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode: read issue and next values of the status flags.
  always_comb begin
    issue_s    = 1'b0;
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    if ((state_r == READ) && (occ_s < 3'd2)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
    case (state_nxt_s)
      READ:    busy_nxt_s = 1'b1;
      DRAIN:   busy_nxt_s = 1'b1;
      FIN:     done_nxt_s = 1'b1;
      default: busy_nxt_s = 1'b0;
    endcase
  end

  // Status flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
    end
  end

  // Issue counter and captured bank; the counter parks on the last index instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx_r <= '0;
      bank_r   <= 1'b0;
    end else if (start_acc_s) begin
      rd_idx_r <= '0;
      bank_r   <= bank_sel;
    end else if (issue_s && (rd_idx_r != LAST_IDX)) begin
      rd_idx_r <= rd_idx_r + {{(BITS_PER_ROW-1){1'b0}}, 1'b1};
    end else begin
      rd_idx_r <= rd_idx_r;
    end
  end

  // Tags of the read whose data returns next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
`ifdef FFT_UNSCR_IDX_EN
      inflight_idx_r  <= '0;
`endif
    end else begin
      inflight_r      <= issue_s;
      inflight_last_r <= last_issue_s;
`ifdef FFT_UNSCR_IDX_EN
      inflight_idx_r  <= rd_idx_r;
`endif
    end
  end

  // Assemble the entry written into the FIFO from returning RAM data.
  always_comb begin
    push_entry_s      = '0;
    push_entry_s.data = bus.mem_rd_data;
    push_entry_s.last = inflight_last_r;
`ifdef FFT_UNSCR_IDX_EN
    push_entry_s.idx  = inflight_idx_r;
`endif
  end

  // Two-entry skid FIFO; head_r always holds the oldest entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) head_r <= push_entry_s;
          else                 tail_r <= push_entry_s;
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          head_r  <= tail_r;
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            head_r <= push_entry_s;
          end else begin
            head_r <= tail_r;
            tail_r <= push_entry_s;
          end
        end
        default: count_r <= count_r;
      endcase
    end
  end

  assign busy            = busy_r;
  assign done            = done_r;
  assign bus.mem_rd_en   = issue_s;
  assign bus.mem_rd_bank = bank_r;
  assign bus.mem_rd_addr = bit_rev(rd_idx_r);
  assign bus.out_valid   = (count_r != 2'd0);
  assign bus.out_data    = head_r.data;
  assign bus.out_last    = head_r.last;
`ifdef FFT_UNSCR_IDX_EN
  assign bus.out_idx     = head_r.idx;
`endif

endmodule

// File: tb/tb_fft_unscrambler.sv
// Directed bench for fft_unscrambler: table of frames with ready patterns, plus reset corner sequences.
module tb_fft_unscrambler;
  localparam int N = 8;
  localparam int B = 3;
  localparam int W = 32;

  typedef struct {
    logic        bank;
    logic [3:0]  pat;
    logic        rnd;
    int          inj;
    int          exp_done;
    logic [31:0] base;
  } frame_t;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic start    = 1'b0;
  logic bank_sel = 1'b0;
  logic busy;
  logic done;

  int checks = 0;
  int errors = 0;
  int rev_tab[8];
  frame_t frames[5];

  fft_unscrambler_if #(.BITS_PER_ROW(B), .DATA_W(W)) bus ();

  fft_unscrambler #(.N(N), .BITS_PER_ROW(B), .DATA_W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bank_sel (bank_sel),
    .busy     (busy),
    .done     (done),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // RAM model: bank 0 holds 0x100+a, bank 1 holds 0x200+a, one cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= (bus.mem_rd_bank ? 32'h200 : 32'h100) + 32'(bus.mem_rd_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_frame(input frame_t f);
    int issued, beats, first_v, done_c;
    logic injected, pv, prdy, rdy;
    logic [31:0] pd;
    issued = 0; beats = 0; first_v = -1; done_c = -1;
    injected = 1'b0; pv = 1'b0; prdy = 1'b0; pd = 32'h0;
    start = 1'b1;
    bank_sel = f.bank;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 200 && done_c < 0; c++) begin
      rdy = f.rnd ? 1'($urandom_range(0, 1)) : f.pat[c % 4];
      bus.out_ready = rdy;
      if (f.inj == beats && !injected) begin
        start = 1'b1;
        bank_sel = ~f.bank;
        injected = 1'b1;
      end else begin
        start = 1'b0;
      end
      #1;
      if (c == 0) check("busy_after_start", busy, 1'b1);
      if (pv && !prdy) begin
        check("hold_valid", bus.out_valid, 1'b1);
        check("hold_data", bus.out_data, pd);
      end
      if (bus.mem_rd_en) begin
        check("rd_addr", 32'(bus.mem_rd_addr), 32'(rev_tab[issued % 8]));
        check("rd_bank", bus.mem_rd_bank, f.bank);
        check("no_overflow", 32'((issue_room(issued, beats, bus.out_valid && rdy))), 32'd1);
        issued++;
      end
      if (bus.out_valid && first_v < 0) first_v = c;
      if (bus.out_valid && rdy) begin
        check("out_data", bus.out_data, f.base + 32'(rev_tab[beats % 8]));
        check("out_last", bus.out_last, 1'(beats == 7));
`ifdef FFT_UNSCR_IDX_EN
        check("out_idx", 32'(bus.out_idx), 32'(beats % 8));
`endif
        beats++;
      end
      if (done) begin
        done_c = c;
        check("busy_at_done", busy, 1'b0);
      end
      pv = bus.out_valid;
      prdy = rdy;
      pd = bus.out_data;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("done_seen", 32'(done_c >= 0), 32'd1);
    if (f.exp_done >= 0) check("done_cycle", 32'(done_c), 32'(f.exp_done));
    check("first_valid_cycle", 32'(first_v), 32'd2);
    check("beat_count", 32'(beats), 32'd8);
    check("read_count", 32'(issued), 32'd8);
    bus.out_ready = 1'b0;
    #1;
    check("done_pulse_one", done, 1'b0);
    check("idle_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("idle_rd_en", bus.mem_rd_en, 1'b0);
    check("idle_valid", bus.out_valid, 1'b0);
  endtask

  // 1 when a read issued now still fits: outstanding after this cycle's accept must be below 2.
  function automatic logic issue_room(input int issued, input int beats, input logic acc);
    return ((issued - beats - (acc ? 1 : 0)) < 2);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_rd_en"}, bus.mem_rd_en, 1'b0);
    check({tag, "_rd_bank"}, bus.mem_rd_bank, 1'b0);
    check({tag, "_rd_addr"}, 32'(bus.mem_rd_addr), 32'd0);
    check({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check({tag, "_out_data"}, bus.out_data, 32'h0);
    check({tag, "_out_last"}, bus.out_last, 1'b0);
`ifdef FFT_UNSCR_IDX_EN
    check({tag, "_out_idx"}, 32'(bus.out_idx), 32'd0);
`endif
  endtask

  initial begin
    int beats;
    rev_tab = '{0, 4, 2, 6, 1, 5, 3, 7};
    //           bank  pat      rnd   inj exp_done base
    frames[0] = '{1'b0, 4'b1111, 1'b0, -1, 10, 32'h100};
    frames[1] = '{1'b0, 4'b1001, 1'b0, -1, -1, 32'h100};
    frames[2] = '{1'b1, 4'b1111, 1'b0,  3, 10, 32'h200};
    frames[3] = '{1'b1, 4'b0101, 1'b0, -1, -1, 32'h200};
    frames[4] = '{1'b0, 4'b0000, 1'b1, -1, -1, 32'h100};

    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      check("idle_quiet", {31'd0, busy | done | bus.mem_rd_en | bus.out_valid}, 32'd0);
    end

    for (int i = 0; i < 5; i++) run_frame(frames[i]);

    // Abort a bank-1 frame at beat 4 with the consumer stalled.
    start = 1'b1;
    bank_sel = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    beats = 0;
    for (int c = 0; c < 100 && beats < 4; c++) begin
      bus.out_ready = 1'b1;
      #1;
      if (bus.out_valid) beats++;
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    #1;
    check("abort_beats", 32'(beats), 32'd4);
    check("abort_busy_before", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(frames[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
